// File: rtl/event_count_pkg.sv
// Shared constants and helpers for the event counter slice.
package event_count_pkg;

  // Match-mode encodings presented on the mode input.
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_ALL    = 2'd1;
  localparam logic [1:0] MODE_ONE    = 2'd2;
  localparam logic [1:0] MODE_EVEN   = 2'd3;

  // Widest input bus the popcount helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_NCH = 32;

  // Population count over the low nch bits of a zero-extended input vector.
  function automatic int unsigned popcount(input logic [MAX_NCH-1:0] bits,
                                           input int unsigned        nch);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_NCH; i++) begin
      if (i < nch) begin
        cnt = cnt + 32'(bits[i]);
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/event_match.sv
// Combinational decode of the event lines against the selected match mode.
module event_match
  import event_count_pkg::*;
#(
  parameter int unsigned NCH = 3
) (
  input  logic [NCH-1:0] din,
  input  logic [1:0]     mode,
  output logic           match
);

  logic [MAX_NCH-1:0] din_ext;
  int unsigned        ones;

  assign din_ext = MAX_NCH'(din);
  assign ones    = popcount(din_ext, NCH);

  // Select the match condition for the current mode; no state, no pipeline.
  always_comb begin
    match = 1'b0;
    unique case (mode)
      MODE_SINGLE: match = din[0];
      MODE_ALL:    match = &din;
      MODE_ONE:    match = (ones == 1);
      MODE_EVEN:   match = (ones >= 2) && (ones[0] == 1'b0);
      default:     match = 1'b0;
    endcase
  end

endmodule

// File: rtl/event_counter.sv
// Registered event counter: window-gated match, optional edge detect,
// wrap/saturate count, sticky overflow and a one-cycle event strobe.
module event_counter
  import event_count_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NCH      = 3,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned EDGE     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   din,
  input  logic [1:0]       mode,
  input  logic [1:0]       state,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             event_pulse
);

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               EdgeOnly = (EDGE != 0);
  localparam bit               SatMode  = (SATURATE != 0);

  logic             match;
  logic             window;
  logic             qual;
  logic             hit;

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pulse_q, pulse_d;
  logic             qual_q, qual_d;

  event_match #(
    .NCH (NCH)
  ) u_match (
    .din   (din),
    .mode  (mode),
    .match (match)
  );

  // Window is open only in the two "mixed" states 01 and 10.
  assign window = state[0] ^ state[1];
  assign qual   = match & window;
  assign hit    = EdgeOnly ? (qual & ~qual_q) : qual;

  // Next-state: clear beats load beats hit; qual history tracks every cycle.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    pulse_d    = 1'b0;
    qual_d     = qual;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (load) begin
      // A coincident hit is intentionally dropped.
      count_d = load_val;
    end else if (hit) begin
      pulse_d = 1'b1;
      if (count_q != CountMax) begin
        count_d = count_q + CountOne;
      end else begin
        overflow_d = 1'b1;
        if (!SatMode) begin
          count_d = '0;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
      qual_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
      qual_q     <= qual_d;
    end
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign event_pulse = pulse_q;

endmodule

// File: doc/event_counter.md
# event_counter

Registered, parametrised event counter: the next generation of the combinational mode-select counter. It watches `NCH` input lines, decides each cycle whether they match the selected mode, and gates the match with a two-bit state window. On a qualifying event it increments an internal `WIDTH`-bit count, either wrapping or saturating. It adds clear/load control, optional edge-only counting, a sticky overflow flag and a registered event strobe. It sits between the input conditioning logic and the display/score logic of the project.

## Interface
- `WIDTH`, 8, count width in bits (≥2)
- `NCH`, 3, number of event input lines (≥2)
- `SATURATE`, 0, 0 = wrap at max, 1 = hold at max
- `EDGE`, 1, 1 = count only the rising edge of a qualified match, 0 = count every qualified cycle

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `din`  in  NCH  event input lines, already synchronous to `clk`
- `mode`  in  2  match mode select
- `state`  in  2  window state; counting enabled only when `state[0]^state[1]`
- `clear`  in  1  synchronous clear of count and overflow
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  WIDTH  value loaded when `load`
- `count`  out  WIDTH  current count (registered)
- `overflow`  out  1  sticky; set on wrap or saturation hit
- `event_pulse`  out  1  one-cycle strobe, high the cycle after a counted event

## Operation
- Match, per `mode`:
  - 0 SINGLE: `din[0]`
  - 1 ALL: every bit of `din` is 1
  - 2 ONE: popcount(`din`) == 1
  - 3 EVEN: popcount even and ≥2
- `qual = match & (state[0]^state[1])`.
- `qual_q` register holds the previous-cycle `qual`.
  - `EDGE=1`: `hit = qual & ~qual_q`
  - `EDGE=0`: `hit = qual`
- Per-cycle priority: `rst` > `clear` > `load` > `hit`.
  - `clear`: count←0, overflow←0, event_pulse←0.
  - `load`: count←`load_val`; overflow unchanged; event_pulse←0; any `hit` in the same cycle is dropped.
  - `hit`:
    - if count < 2^WIDTH−1, count←count+1.
    - if count == max and `SATURATE=0`, count←0 and overflow←1.
    - if count == max and `SATURATE=1`, count holds and overflow←1.
    - event_pulse←1 in every `hit` case, including saturated ones.
  - otherwise: count holds, event_pulse←0.
- `qual_q` updates every cycle regardless of `clear`/`load`; only `rst` forces it to 0.
- Arithmetic is unsigned, modulo 2^WIDTH; no intermediate wider than WIDTH+1.

## Timing
- Reset values: count=0, overflow=0, event_pulse=0, qual_q=0.
- Latency: `din`/`state` sampled at edge N, new count visible after edge N; `event_pulse` is high for the cycle following edge N.
- Mode or window changes take effect in the same cycle they are presented; there is no pipeline.
- `EDGE=1`, qualification held high K cycles: exactly one increment. When `qual` drops and rises again, the next rising edge increments again.
- `EDGE=1`, window closes while match stays high, then reopens: counts again, because `qual` restarted.
- Reset asserted mid-run: all registers return to reset values at the next edge. The first cycle after reset with `qual=1` counts under `EDGE=1`.

## Structure
- Package `event_count_pkg`:
  - mode constants `MODE_SINGLE=2'd0`, `MODE_ALL=2'd1`, `MODE_ONE=2'd2`, `MODE_EVEN=2'd3`
  - a popcount function parametrised on `NCH`
- Sub-module `event_match`: combinational decode of `din` and `mode` to `match`, parametrised on `NCH`.
- `event_counter` holds `qual_q`, count, overflow and event_pulse.

## Test plan
- Reset, then `mode=1`, `din=3'b111`, `state=2'b01`, `EDGE=1`, held 5 cycles → count=1, event_pulse high exactly one cycle.
- `EDGE=0`, `mode=3`, `din=3'b011`, `state=2'b10`, held 4 cycles → count=4. Then `din=3'b111` → no further increment, since popcount 3 is odd.
- `state=2'b11`, `mode=0`, `din[0]` toggling 10 times → count stays 0, event_pulse never high.
- `WIDTH=8`, `load_val=8'hFF`, load, then one hit:
  - `SATURATE=0` → count=0, overflow=1.
  - `SATURATE=1` → count=FF, overflow=1.
  - then `clear` → count=0, overflow=0.
- `load=1` with `load_val=8'h10` and a hit in the same cycle → count=10, event_pulse=0. `clear` and `load` together → count=0.
- `rst` asserted while count=8'h2A and `qual=1` → next cycle count=0, overflow=0. With `rst` deasserted and `qual` still 1 under `EDGE=1` → count=1.
